// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : N-channel push-button front end. Each raw button is synchronised,
//            debounced and turned into a one-cycle press pulse. Presses are
//            queued as pending events and presented lowest-index first behind
//            a valid/ack handshake. One event is consumed per physical press.
// Ports    :
//   clk          in   1      system clock
//   reset        in   1      asynchronous reset, active low
//   btn_raw      in   N_BTN  raw asynchronous button levels (1 = pressed)
//   enable       in   1      0 = presses are not recorded as events
//   btn_level    out  N_BTN  debounced button levels
//   btn_press    out  N_BTN  one-cycle pulse on each debounced rising edge
//   event_valid  out  1      at least one event is pending
//   event_idx    out  IDX_W  channel of the presented (lowest pending) event
//   event_ack    in   1      consumer accepts the presented event
//   overrun      out  1      one-cycle pulse when a press is lost
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int N_BTN       = 5,
  parameter int DB_CYCLES   = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit EXCLUSIVE   = 1'b0,
  localparam int IDX_W      = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             event_valid,
  output logic [IDX_W-1:0] event_idx,
  input  logic             event_ack,
  output logic             overrun
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Per-channel synchroniser + debouncer + rising-edge pulse
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Any sample that agrees with the accepted level restarts the count, so
    // only DB_CYCLES consecutive disagreeing samples can flip the level.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        level_d = ~level_q;
        press_d = ~level_q;  // pulse only on the 0->1 transition
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_press[i] = press_q;
  end

  // --------------------------------------------------------------------------
  // Pending-event register
  // --------------------------------------------------------------------------
  logic [N_BTN-1:0] pend_q, pend_d;
  logic             overrun_q, overrun_d;
  logic [N_BTN-1:0] ack_vec;
  logic [N_BTN-1:0] press_acc;
  logic [N_BTN-1:0] pend_kept;
  logic [IDX_W-1:0] sel_idx;

  // Lowest set index wins; scanning downward lets the lowest overwrite last.
  always_comb begin
    sel_idx = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    // x & -x isolates the lowest set bit, i.e. the presented event. With no
    // event pending this is zero, so a stray ack has no effect.
    ack_vec   = event_ack ? (pend_q & (~pend_q + 1'b1)) : '0;
    press_acc = enable ? btn_press : '0;
    pend_kept = pend_q & ~ack_vec;
    pend_d    = pend_kept;
    overrun_d = 1'b0;

    if (EXCLUSIVE == 1'b0) begin
      // Setting after the ack clear makes a same-cycle press+ack keep the bit.
      pend_d    = pend_kept | press_acc;
      overrun_d = |(press_acc & pend_kept);
    end else if (press_acc != '0) begin
      // Accept a single press only when nothing remains pending after ack;
      // simultaneous contenders are all dropped with one overrun pulse.
      if ((pend_kept == '0) && ((press_acc & (press_acc - 1'b1)) == '0)) begin
        pend_d = press_acc;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign event_valid = |pend_q;
  assign event_idx   = sel_idx;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. Two instances share
//            the button stimulus: dut0 queues every press, dut1 is exclusive.
//            A behavioural model (raw-sample history + event-set rules) is
//            compared against both instances every cycle, alongside a table
//            of checkpoint vectors and hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int DB   = 16;
  localparam int SYNC = 2;
  localparam int IW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  btn_raw;
  logic          enable;
  logic          ack0, ack1;
  logic [N-1:0]  lvl0, prs0, lvl1, prs1;
  logic          v0, v1, o0, o1;
  logic [IW-1:0] i0, i1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  button_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .SYNC_STAGES(SYNC), .EXCLUSIVE(1'b0)) dut0 (
    .clk(clk), .reset(rst_n), .btn_raw(btn_raw), .enable(enable),
    .btn_level(lvl0), .btn_press(prs0), .event_valid(v0), .event_idx(i0),
    .event_ack(ack0), .overrun(o0)
  );

  button_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .SYNC_STAGES(SYNC), .EXCLUSIVE(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .btn_raw(btn_raw), .enable(enable),
    .btn_level(lvl1), .btn_press(prs1), .event_valid(v1), .event_idx(i1),
    .event_ack(ack1), .overrun(o1)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [N-1:0][63:0] hist;   // raw samples, bit 0 = most recent edge
    logic [N-1:0]       level;
    logic [N-1:0]       press;
    logic [N-1:0]       pend0;
    logic [N-1:0]       pend1;
    logic               ovr0;
    logic               ovr1;
  } mstate_t;

  mstate_t m;

  function automatic logic [IW-1:0] lowest(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return IW'(i);
    return '0;
  endfunction

  function automatic logic [N-1:0] pend_next(input logic [N-1:0] pend, input logic [N-1:0] press,
                                             input logic en, input logic ack, input logic excl,
                                             output logic ovr);
    int           acked;
    logic [N-1:0] nxt;
    bit           free;
    acked = -1;
    if (ack) for (int i = N - 1; i >= 0; i--) if (pend[i]) acked = i;
    nxt = pend;
    if (acked >= 0) nxt[acked] = 1'b0;
    ovr = 1'b0;
    if (en && press != '0) begin
      if (!excl) begin
        for (int i = 0; i < N; i++) begin
          if (press[i]) begin
            if (pend[i] && i != acked) ovr = 1'b1;
            nxt[i] = 1'b1;
          end
        end
      end else begin
        free = (pend == '0) || (acked >= 0);
        if (free && $countones(press) == 1) nxt = nxt | press;
        else ovr = 1'b1;
      end
    end
    return nxt;
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input logic [N-1:0] raw, input logic en,
                                         input logic a0, input logic a1);
    mstate_t n;
    logic    o;
    bit      flip;
    n = c;
    n.pend0 = pend_next(c.pend0, c.press, en, a0, 1'b0, o);
    n.ovr0  = o;
    n.pend1 = pend_next(c.pend1, c.press, en, a1, 1'b1, o);
    n.ovr1  = o;
    for (int ch = 0; ch < N; ch++) begin
      n.hist[ch] = {c.hist[ch][62:0], raw[ch]};
      // The debouncer sees raw delayed by SYNC edges; the level flips once the
      // last DB of those delayed samples all disagree with it.
      flip = 1'b1;
      for (int j = 0; j < DB; j++) if (n.hist[ch][SYNC+j] == c.level[ch]) flip = 1'b0;
      n.level[ch] = c.level[ch] ^ flip;
      n.press[ch] = flip & ~c.level[ch];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, btn_raw, enable, ack0, ack1);
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string nm,
                           input logic [N-1:0] al, input logic [N-1:0] ap, input logic av,
                           input logic [IW-1:0] ai, input logic ao,
                           input logic [N-1:0] el, input logic [N-1:0] ep, input logic ev,
                           input logic [IW-1:0] ei, input logic eo);
    logic [2*N+IW+1:0] act, exp;
    act = {al, ap, av, ev ? ai : '0, ao};
    exp = {el, ep, ev, ev ? ei : '0, eo};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      if (n_miss <= 20)
        $display("FAIL %s t=%0t: got lvl=%b prs=%b v=%b idx=%0d ovr=%b, expected lvl=%b prs=%b v=%b idx=%0d ovr=%b",
                 nm, $time, al, ap, av, ai, ao, el, ep, ev, ei, eo);
    end
  endtask

  always @(negedge clk) begin
    check_obs("model_dut0", lvl0, prs0, v0, i0, o0, m.level, m.press, m.pend0 != '0, lowest(m.pend0), m.ovr0);
    check_obs("model_dut1", lvl1, prs1, v1, i1, o1, m.level, m.press, m.pend1 != '0, lowest(m.pend1), m.ovr1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_both();
    ack0 = 1'b1; ack1 = 1'b1;
    tick(1);
    ack0 = 1'b0; ack1 = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Checkpoint table: ack pulses on the first cycle only, then inputs are held
  // for the remaining cycles before outputs are compared.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]  raw;
    logic          en, a0, a1;
    int            cycles;
    logic [N-1:0]  lvl;
    logic          v0;
    logic [IW-1:0] i0;
    logic          v1;
    logic [IW-1:0] i1;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int            seen, cnt, cnt1;
    logic [IW-1:0] ti0, ti1;

    tbl[0]  = '{5'b01000, 1'b1, 1'b0, 1'b0, 25, 5'b01000, 1'b1, 3'd3, 1'b1, 3'd3};
    tbl[1]  = '{5'b01010, 1'b1, 1'b0, 1'b0, 25, 5'b01010, 1'b1, 3'd1, 1'b1, 3'd3};
    tbl[2]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 25, 5'b00000, 1'b1, 3'd1, 1'b1, 3'd3};
    tbl[3]  = '{5'b00000, 1'b1, 1'b1, 1'b0,  1, 5'b00000, 1'b1, 3'd3, 1'b1, 3'd3};
    tbl[4]  = '{5'b00000, 1'b1, 1'b1, 1'b1,  1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[5]  = '{5'b10100, 1'b1, 1'b0, 1'b0, 25, 5'b10100, 1'b1, 3'd2, 1'b0, 3'd0};
    tbl[6]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 25, 5'b00000, 1'b1, 3'd2, 1'b0, 3'd0};
    tbl[7]  = '{5'b00000, 1'b1, 1'b1, 1'b0,  1, 5'b00000, 1'b1, 3'd4, 1'b0, 3'd0};
    tbl[8]  = '{5'b00000, 1'b1, 1'b1, 1'b0,  1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[9]  = '{5'b00100, 1'b1, 1'b0, 1'b0, 25, 5'b00100, 1'b1, 3'd2, 1'b1, 3'd2};
    tbl[10] = '{5'b10100, 1'b1, 1'b0, 1'b0, 25, 5'b10100, 1'b1, 3'd2, 1'b1, 3'd2};
    tbl[11] = '{5'b00000, 1'b1, 1'b0, 1'b0, 25, 5'b00000, 1'b1, 3'd2, 1'b1, 3'd2};
    tbl[12] = '{5'b00000, 1'b1, 1'b1, 1'b1,  1, 5'b00000, 1'b1, 3'd4, 1'b0, 3'd0};
    tbl[13] = '{5'b00000, 1'b1, 1'b1, 1'b0,  1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[14] = '{5'b00001, 1'b0, 1'b0, 1'b0, 25, 5'b00001, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[15] = '{5'b00000, 1'b0, 1'b0, 1'b0, 25, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0};

    // ---- Reset with button 0 held -----------------------------------------
    rst_n = 1'b0; btn_raw = 5'b00001; enable = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
    tick(3);
    check("reset_outputs", 32'({lvl0, prs0, v0, i0, o0, lvl1, prs1, v1, i1, o1}), 32'd0);
    rst_n = 1'b1;
    tick(17);
    check("press_before_18", 32'({prs0, prs1}), 32'd0);
    tick(1);
    check("press_at_18", 32'({prs0, prs1}), 32'({5'b00001, 5'b00001}));
    tick(1);
    check("event_at_19", 32'({prs0, v0, i0, v1, i1}), 32'({5'b00000, 1'b1, 3'd0, 1'b1, 3'd0}));
    ack_both();
    check("ack_clears", 32'({v0, v1}), 32'd0);
    btn_raw = '0;
    tick(25);

    // ---- Table-driven checkpoints ------------------------------------------
    for (int k = 0; k < 16; k++) begin
      btn_raw = tbl[k].raw; enable = tbl[k].en; ack0 = tbl[k].a0; ack1 = tbl[k].a1;
      tick(1);
      ack0 = 1'b0; ack1 = 1'b0;
      tick(tbl[k].cycles - 1);
      ti0 = v0 ? i0 : '0;
      ti1 = v1 ? i1 : '0;
      check($sformatf("table_row%0d", k), 32'({lvl0, v0, ti0, v1, ti1}),
            32'({tbl[k].lvl, tbl[k].v0, tbl[k].i0, tbl[k].v1, tbl[k].i1}));
    end
    enable = 1'b1;

    // ---- Glitch rejection: 10 and 15 cycles rejected, 16 accepted ----------
    seen = 0;
    btn_raw = 5'b00010; tick(10); btn_raw = '0;
    for (int c = 0; c < 25; c++) begin tick(1); seen += int'(lvl0[1] | prs0[1] | v0 | v1); end
    btn_raw = 5'b00010; tick(15); btn_raw = '0;
    for (int c = 0; c < 25; c++) begin tick(1); seen += int'(lvl0[1] | prs0[1] | v0 | v1); end
    check("glitch_reject", 32'(seen), 32'd0);
    cnt = 0;
    btn_raw = 5'b00010; tick(16); btn_raw = '0;
    for (int c = 0; c < 25; c++) begin tick(1); cnt += int'(prs0[1]); end
    check("sixteen_accept", 32'({cnt[7:0], v0, i0}), 32'({8'd1, 1'b1, 3'd1}));
    ack_both();
    tick(20);
    cnt = 0;
    btn_raw = 5'b00010;
    for (int c = 0; c < 100; c++) begin tick(1); cnt += int'(prs0[1]); end
    check("hold_one_press", 32'(cnt), 32'd1);
    check("hold_event", 32'({v0, i0, v1, i1}), 32'({1'b1, 3'd1, 1'b1, 3'd1}));
    ack_both();
    btn_raw = '0; tick(25);

    // ---- Second press on channel 3 before ack -> one overrun --------------
    cnt = 0; cnt1 = 0;
    for (int r = 0; r < 4; r++) begin
      btn_raw = (r % 2 == 0) ? 5'b01000 : 5'b00000;
      for (int c = 0; c < 25; c++) begin tick(1); cnt += int'(o0); cnt1 += int'(o1); end
    end
    check("overrun_once", 32'({cnt[7:0], cnt1[7:0], v0, i0}), 32'({8'd1, 8'd1, 1'b1, 3'd3}));
    ack_both();
    tick(2);

    // ---- Enable low: silent discard ----------------------------------------
    cnt = 0; enable = 1'b0;
    btn_raw = 5'b00001;
    for (int c = 0; c < 25; c++) begin tick(1); cnt += int'(o0 | o1); end
    btn_raw = '0;
    for (int c = 0; c < 25; c++) begin tick(1); cnt += int'(o0 | o1); end
    check("disabled_silent", 32'({cnt[7:0], v0, v1}), 32'd0);
    enable = 1'b1;

    // ---- Ack of channel 0 coincident with a new channel 0 press -----------
    btn_raw = 5'b00001; tick(25); btn_raw = '0; tick(25);
    btn_raw = 5'b00001;
    tick(18);
    check("corner_align", 32'(prs0), 32'd1);
    ack_both();
    check("ack_press_dut0", 32'({v0, i0, o0}), 32'({1'b1, 3'd0, 1'b0}));
    check("ack_press_dut1", 32'({v1, i1, o1}), 32'({1'b1, 3'd0, 1'b0}));
    btn_raw = '0; tick(25);
    ack_both();
    check("corner_drained", 32'({v0, v1}), 32'd0);

    // ---- Asynchronous reset mid-operation ----------------------------------
    btn_raw = 5'b00010; tick(25);
    btn_raw = 5'b00100; tick(25);
    check("pend_00110", 32'({v0, i0}), 32'({1'b1, 3'd1}));
    btn_raw = 5'b01000; tick(8);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 32'({lvl0, prs0, v0, i0, o0, lvl1, prs1, v1, i1, o1}), 32'd0);
    btn_raw = '0;
    tick(3);
    rst_n = 1'b1;
    tick(30);
    check("no_stale_event", 32'({lvl0, v0, v1}), 32'd0);

    // ---- Randomised traffic against the model ------------------------------
    for (int c = 0; c < 4000; c++) begin
      int b;
      if ($urandom_range(0, 7) == 0) begin
        b = int'($urandom_range(0, N - 1));
        btn_raw[b] = ~btn_raw[b];
      end
      if (c < 2000) begin
        ack0 = ($urandom_range(0, 3) == 0);
        ack1 = ($urandom_range(0, 3) == 0);
      end else begin
        ack0 = ($urandom_range(0, 31) == 0);
        ack1 = ($urandom_range(0, 31) == 0);
      end
      enable = ($urandom_range(0, 15) != 0);
      tick(1);
    end
    ack0 = 1'b0; ack1 = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
